// File: rtl/bist_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : bist_pattern_gen
// Brief    : Galois-LFSR stimulus source for scan-mapped BIST. It emits a
//            programmable number of {primary_input, pseudo_input} patterns.
// Options  : BIST_ZERO_PATTERN_EN - first pattern of each run is all-zeros
// Revision : 1.0 - initial release
// ============================================================================
module bist_pattern_gen #(
    parameter int PI_WIDTH  = 4,
    parameter int PPI_WIDTH = 3,
    parameter int CNT_WIDTH = 16,
    parameter logic [PI_WIDTH+PPI_WIDTH-1:0] TAPS = 7'h60,
    parameter logic [PI_WIDTH+PPI_WIDTH-1:0] SEED = 7'h01
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          seed_load,
    input  logic [PI_WIDTH+PPI_WIDTH-1:0] seed,
    input  logic [CNT_WIDTH-1:0]          num_patterns,
    input  logic                          hold,
    output logic [PI_WIDTH-1:0]           primary_input,
    output logic [PPI_WIDTH-1:0]          pseudo_input,
    output logic                          pattern_valid,
    output logic [CNT_WIDTH-1:0]          pattern_index,
    output logic                          busy,
    output logic                          done
);

    localparam int W = PI_WIDTH + PPI_WIDTH;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [W-1:0]         c_LFSR_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

`ifdef BIST_ZERO_PATTERN_EN
    localparam logic c_ZERO_EN = 1'b1;
`else
    localparam logic c_ZERO_EN = 1'b0;
`endif

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [W-1:0]         r_lfsr;
    logic [W-1:0]         w_lfsr_nxt;
    logic [W-1:0]         w_lfsr_step;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [CNT_WIDTH-1:0] w_count_inc;
    logic [CNT_WIDTH-1:0] r_n;
    logic [CNT_WIDTH-1:0] w_n_nxt;
    logic [W-1:0]         r_pattern;
    logic [W-1:0]         w_pattern_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic [CNT_WIDTH-1:0] r_index;
    logic [CNT_WIDTH-1:0] w_index_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_zero_slot;
    logic                 w_take_start;

    assign w_lfsr_step  = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
    assign w_count_inc  = r_count + c_CNT_ONE;
    assign w_zero_slot  = c_ZERO_EN && (r_count == '0);
    // A seed load in the same cycle wins over start.
    assign w_take_start = start && !seed_load;

    // State and datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= c_IDLE;
            r_lfsr    <= SEED;
            r_count   <= '0;
            r_n       <= '0;
            r_pattern <= '0;
            r_valid   <= 1'b0;
            r_index   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_count   <= w_count_nxt;
            r_n       <= w_n_nxt;
            r_pattern <= w_pattern_nxt;
            r_valid   <= w_valid_nxt;
            r_index   <= w_index_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_take_start) begin
                    w_state_nxt = (num_patterns == '0) ? c_DONE : c_RUN;
                end
            end
            c_RUN: begin
                if (!hold && (w_count_inc == r_n)) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        w_lfsr_nxt    = r_lfsr;
        w_count_nxt   = r_count;
        w_n_nxt       = r_n;
        w_pattern_nxt = r_pattern;
        w_valid_nxt   = 1'b0;
        w_index_nxt   = r_index;
        w_done_nxt    = 1'b0;
        w_busy_nxt    = (w_state_nxt != c_IDLE);
        case (r_state)
            c_IDLE: begin
                if (seed_load) begin
                    w_lfsr_nxt = (seed == '0) ? c_LFSR_ONE : seed;
                end else if (start) begin
                    w_n_nxt     = num_patterns;
                    w_count_nxt = '0;
                end
            end
            c_RUN: begin
                if (!hold) begin
                    w_valid_nxt = 1'b1;
                    w_index_nxt = r_count;
                    w_count_nxt = w_count_inc;
                    // The optional zero slot consumes a count but not an LFSR step.
                    if (w_zero_slot) begin
                        w_pattern_nxt = '0;
                    end else begin
                        w_pattern_nxt = r_lfsr;
                        w_lfsr_nxt    = w_lfsr_step;
                    end
                end
            end
            c_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_done_nxt = 1'b0;
            end
        endcase
    end

    assign primary_input = r_pattern[W-1:PPI_WIDTH];
    assign pseudo_input  = r_pattern[PPI_WIDTH-1:0];
    assign pattern_valid = r_valid;
    assign pattern_index = r_index;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bist_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_bist_pattern_gen
// Brief    : Scoreboard bench for bist_pattern_gen (default parameters).
//            Honours BIST_ZERO_PATTERN_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bist_pattern_gen;

    logic        clock;
    logic        resetn;
    logic        start;
    logic        seed_load;
    logic [6:0]  seed;
    logic [15:0] num_patterns;
    logic        hold;
    logic [3:0]  primary_input;
    logic [2:0]  pseudo_input;
    logic        pattern_valid;
    logic [15:0] pattern_index;
    logic        busy;
    logic        done;

`ifdef BIST_ZERO_PATTERN_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    bist_pattern_gen dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .seed_load     (seed_load),
        .seed          (seed),
        .num_patterns  (num_patterns),
        .hold          (hold),
        .primary_input (primary_input),
        .pseudo_input  (pseudo_input),
        .pattern_valid (pattern_valid),
        .pattern_index (pattern_index),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [22:0] exp_q[$];   // {index, pattern}
    int          done_q[$];  // patterns expected before each done pulse
    int          pat_since = 0;
    bit          track = 1'b0;
    bit          seen[0:127];
    logic [6:0]  m_lfsr;

    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        return v[0] ? ((v >> 1) ^ 7'h60) : (v >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a pattern or done.
    always @(negedge clock) begin
        if (!resetn) begin
            pat_since = 0;
        end else begin
            if (pattern_valid) begin
                logic [6:0] pat;
                pat = {primary_input, pseudo_input};
                if (exp_q.size() == 0) begin
                    chk("unexpected_pattern", {9'd0, pattern_index, pat}, 32'hFFFF_FFFF);
                end else begin
                    logic [22:0] e;
                    e = exp_q.pop_front();
                    chk("pattern", {25'd0, pat}, {25'd0, e[6:0]});
                    chk("pattern_index", {16'd0, pattern_index}, {16'd0, e[22:7]});
                end
                if (track && !(ZERO_EN && pattern_index == 16'd0)) begin
                    chk("distinct_nonzero", {31'd0, (pat != 7'd0) && !seen[pat]}, 32'd1);
                    seen[pat] = 1'b1;
                end
                pat_since++;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("patterns_before_done", pat_since, done_q.pop_front());
                end
                pat_since = 0;
            end
        end
    end

    task automatic push_run(input int n);
        for (int i = 0; i < n; i++) begin
            logic [6:0] p;
            if (ZERO_EN && i == 0) begin
                p = 7'd0;
            end else begin
                p = m_lfsr;
                m_lfsr = lfsr_step(m_lfsr);
            end
            exp_q.push_back({i[15:0], p});
        end
    endtask

    task automatic do_seed(input logic [6:0] s);
        @(negedge clock);
        seed_load = 1'b1;
        seed = s;
        @(negedge clock);
        seed_load = 1'b0;
        m_lfsr = (s == 7'd0) ? 7'h01 : s;
    endtask

    task automatic run_start(input int n);
        @(negedge clock);
        start = 1'b1;
        num_patterns = n[15:0];
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
        chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    logic [6:0] tab1[8];

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        seed_load = 1'b0;
        seed = 7'd0;
        num_patterns = 16'd0;
        hold = 1'b0;
        for (int i = 0; i < 128; i++) seen[i] = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_pi", {28'd0, primary_input}, 32'd0);
        chk("rst_ppi", {29'd0, pseudo_input}, 32'd0);
        chk("rst_valid", {31'd0, pattern_valid}, 32'd0);
        chk("rst_index", {16'd0, pattern_index}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        resetn = 1'b1;

        // Hand-computed sequence from seed 01
        do_seed(7'h01);
        if (ZERO_EN) begin
            tab1 = '{7'h00, 7'h01, 7'h60, 7'h30, 7'h18, 7'h0C, 7'h06, 7'h03};
            m_lfsr = 7'h61;
        end else begin
            tab1 = '{7'h01, 7'h60, 7'h30, 7'h18, 7'h0C, 7'h06, 7'h03, 7'h61};
            m_lfsr = 7'h50;
        end
        for (int i = 0; i < 8; i++) exp_q.push_back({i[15:0], tab1[i]});
        done_q.push_back(8);
        run_start(8);
        chk("run_busy", {31'd0, busy}, 32'd1);
        wait_done("n8", 50);

        // Hold for 3 cycles after two patterns
        push_run(5);
        done_q.push_back(5);
        run_start(5);
        repeat (2) @(negedge clock);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("hold_valid_low", {31'd0, pattern_valid}, 32'd0);
        end
        hold = 1'b0;
        wait_done("hold", 50);

        // Zero seed maps to 1, then full period and wrap
        do_seed(7'h00);
        for (int i = 0; i < 128; i++) seen[i] = 1'b0;
        track = 1'b1;
        push_run(127);
        done_q.push_back(127);
        run_start(127);
        wait_done("n127", 300);
        track = 1'b0;
        push_run(1);
        done_q.push_back(1);
        run_start(1);
        wait_done("n1_wrap", 20);

        // Zero-length run: done the cycle after start, no patterns
        done_q.push_back(0);
        run_start(0);
        @(negedge clock);
        chk("n0_done", {31'd0, done}, 32'd1);
        chk("n0_valid", {31'd0, pattern_valid}, 32'd0);
        @(negedge clock);

        // start / seed_load / num_patterns ignored while busy
        push_run(4);
        done_q.push_back(4);
        run_start(4);
        @(negedge clock);
        start = 1'b1;
        seed_load = 1'b1;
        seed = 7'h55;
        num_patterns = 16'd2;
        @(negedge clock);
        start = 1'b0;
        seed_load = 1'b0;
        wait_done("ignore", 50);

        // Reset at pattern 3 of 8: no done, back to SEED
        push_run(3);
        run_start(8);
        repeat (3) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, pattern_valid}, 32'd0);
        chk("midrst_pattern", {25'd0, primary_input, pseudo_input}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
        #2 resetn = 1'b1;
        m_lfsr = 7'h01;
        repeat (3) @(negedge clock);
        chk("midrst_no_done", {31'd0, done}, 32'd0);
        push_run(2);
        done_q.push_back(2);
        run_start(2);
        wait_done("after_rst", 20);

        repeat (3) @(negedge clock);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("done_q_drained", done_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
